// File: rtl/apb_wait_slave_mem.sv
// APB completer with a DEPTH x DATA_WIDTH register memory, programmable wait states and external stall.
// Optional build macro APB_SLVERR_EN: paddr >= DEPTH answers with pslverr instead of wrapping.
`timescale 1ns/1ps

module apb_wait_slave_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int WAIT_W     = 4
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [WAIT_W-1:0]     wait_cfg,
  input  logic                  ext_wait,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  busy_q, busy_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  setup;

  assign setup = psel && !penable;

`ifdef APB_SLVERR_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  logic oor_q, oor_d;
  logic pslverr_q, pslverr_d;
`else
  logic unused_paddr;
  assign unused_paddr = ^paddr;
`endif

  // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      busy_q   <= busy_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = paddr[AW-1:0];
          wdata_d = pwdata;
          write_d = pwrite;
          cnt_d   = wait_cfg;
          state_d = (wait_cfg == '0 && !ext_wait) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (!ext_wait) begin
          if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q <= WAIT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory access happens on the edge that raises pready, so read data and pready appear together.
  always_comb begin
    pready_d = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    prdata_d = prdata_q;
    mem_we   = 1'b0;
`ifdef APB_SLVERR_EN
    pslverr_d = 1'b0;
    if (pready_d) begin
      pslverr_d = oor_d;
      if (write_d) mem_we   = !oor_d;
      else         prdata_d = oor_d ? '0 : mem_q[addr_d];
    end
`else
    if (pready_d) begin
      if (write_d) mem_we   = 1'b1;
      else         prdata_d = mem_q[addr_d];
    end
`endif
  end

`ifdef APB_SLVERR_EN
  always_comb begin
    oor_d = oor_q;
    if (state_q == S_IDLE && setup) oor_d = ({1'b0, paddr} >= DEPTH_L);
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      oor_q     <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      oor_q     <= oor_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

  // NOTE: the array is reset because contents must read as zero after reset; this keeps it in flops, not RAM macros.
  always_ff @(posedge pclk) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_d] <= wdata_d;
    end
  end

  assign prdata = prdata_q;
  assign pready = pready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_apb_wait_slave_mem.sv
// Scoreboard bench for apb_wait_slave_mem: the driver pushes expected responses from a word-array model,
// a negedge monitor pops and compares data, pslverr and access-phase length on every pready.
`timescale 1ns/1ps

module tb_apb_wait_slave_mem;

  localparam int DEPTH = 64;

  logic       pclk = 1'b0;
  logic       prst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [3:0] wait_cfg;
  logic       ext_wait;
  logic [7:0] prdata;
  logic       pready, pslverr, busy;

  always #5 pclk = ~pclk;

  apb_wait_slave_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(DEPTH), .WAIT_W(4)
  ) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .wait_cfg(wait_cfg), .ext_wait(ext_wait),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
  );

  typedef struct {
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] rdata;
    bit         slverr;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem_model [DEPTH];
  logic [7:0] last_rd;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         acc_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  // Reference: word array indexed modulo DEPTH; prdata holds the last read result.
  task automatic model_issue(input bit w, input logic [7:0] a, input logic [7:0] d, input int len);
    exp_t e;
    bit   oor;
    int   idx;
    idx = int'(a) % DEPTH;
`ifdef APB_SLVERR_EN
    oor = (int'(a) >= DEPTH);
`else
    oor = 1'b0;
`endif
    if (w) begin
      if (!oor) mem_model[idx] = d;
    end else begin
      last_rd = oor ? 8'h00 : mem_model[idx];
    end
    e.is_write = w;
    e.addr     = a;
    e.rdata    = last_rd;
    e.slverr   = oor;
    e.len      = len;
    exp_q.push_back(e);
  endtask

  always @(negedge pclk) begin
    if (!prst) begin
      acc_cnt = 0;
    end else begin
      if (psel && penable) acc_cnt++;
      else                 acc_cnt = 0;
      if (pready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pready @%0t: got pready=1 expected no transfer", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check(mon_e.is_write ? "wr_prdata_hold" : "rd_data", prdata, mon_e.rdata);
          check("pslverr", pslverr, mon_e.slverr);
          check("access_len", acc_cnt, mon_e.len);
        end
      end
    end
  end

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0; ext_wait = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // One APB transfer; abort_after >= 0 drops psel after that many access cycles.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                      input logic [3:0] wcfg, input int nstall, input int abort_after = -1);
    int k;
    int ns;
    ns = (wcfg == 4'd0) ? 0 : nstall;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    wait_cfg = wcfg; ext_wait = 1'b0;
    if (abort_after < 0) model_issue(w, a, d, int'(wcfg) + ns + 1);
    @(posedge pclk); #1;
    penable = 1'b1;
    check("busy_in_access", busy, 1);
    k = 0;
    while (!pready) begin
      if (abort_after >= 0 && k == abort_after) begin
        psel = 1'b0; penable = 1'b0; ext_wait = 1'b0;
        @(posedge pclk); #1;
        check("abort_idle_busy", busy, 0);
        check("abort_no_ready", pready, 0);
        return;
      end
      if (k >= 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL pready_timeout @%0t: got no pready expected one within 64 cycles", $time);
        psel = 1'b0; penable = 1'b0; ext_wait = 1'b0;
        return;
      end
      ext_wait = (k < ns);
      @(posedge pclk); #1;
      k++;
    end
    ext_wait = 1'b0;
    @(posedge pclk); #1;
    check("ready_one_cycle", pready, 0);
  endtask

  initial begin
    prst = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; wait_cfg = 4'd0; ext_wait = 1'b0;
    model_reset();
    repeat (2) begin @(posedge pclk); #1; end
    check("reset_prdata", prdata, 0);
    check("reset_pready", pready, 0);
    check("reset_busy", busy, 0);
    check("reset_pslverr", pslverr, 0);
    prst = 1'b1;
    idle(1);

    xfer(1'b0, 8'd5, 8'h00, 4'd0, 0);
    idle(1);

    // Zero-wait write then read
    xfer(1'b1, 8'd3, 8'h2A, 4'd0, 0);
    xfer(1'b0, 8'd3, 8'h00, 4'd0, 0);
    idle(1);

    // Programmed waits
    xfer(1'b1, 8'd10, 8'h55, 4'd3, 0);
    xfer(1'b0, 8'd10, 8'h00, 4'd3, 0);
    idle(2);

    // External stall
    xfer(1'b1, 8'd20, 8'hC3, 4'd1, 2);
    xfer(1'b0, 8'd20, 8'h00, 4'd1, 2);
    idle(1);

    // penable without a setup phase must be ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd7; pwdata = 8'hEE;
    @(posedge pclk); #1;
    check("no_setup_busy", busy, 0);
    check("no_setup_ready", pready, 0);
    idle(1);

    // Abort, then back-to-back traffic
    xfer(1'b1, 8'd7, 8'hFF, 4'd3, 0, 1);
    xfer(1'b0, 8'd7, 8'h00, 4'd0, 0);
    for (int i = 0; i < 32; i++) xfer(1'b1, 8'(i), 8'(3 * i), 4'd0, 0);
    for (int i = 0; i < 32; i++) xfer(1'b0, 8'(i), 8'h00, 4'($urandom_range(0, 2)), 0);
    idle(1);

    // Out-of-range: alias or slave error depending on build
    xfer(1'b1, 8'd64, 8'h11, 4'd0, 0);
    xfer(1'b0, 8'd0, 8'h00, 4'd0, 0);
    xfer(1'b0, 8'd64, 8'h00, 4'd2, 1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
           4'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Reset in the middle of a waited write clears state and memory
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'hAA; wait_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) begin @(posedge pclk); #1; end
    prst = 1'b0;
    @(posedge pclk); #1;
    check("midreset_busy", busy, 0);
    check("midreset_ready", pready, 0);
    check("midreset_prdata", prdata, 0);
    model_reset();
    prst = 1'b1;
    idle(1);
    xfer(1'b0, 8'd9, 8'h00, 4'd0, 0);
    xfer(1'b0, 8'd3, 8'h00, 4'd1, 0);
    xfer(1'b0, 8'd5, 8'h00, 4'd0, 0);
    idle(2);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge pclk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
